// File: rtl/sap1_pkg.sv
// Shared SAP-1 definitions: loader FSM states and memory geometry.
package sap1_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRecv,
    StCsum,
    StWrite,
    StClear
  } fp_state_e;

  localparam logic [7:0]  SYNC_BYTE_DEFAULT = 8'hA5;
  localparam int unsigned MEM_DEPTH         = 16;
  localparam int unsigned MEM_AW            = $clog2(MEM_DEPTH);

endpackage

// File: rtl/fp_loader_buf.sv
// 16x8 frame buffer: synchronous write, combinational read, no reset.
module fp_loader_buf
  import sap1_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [MEM_AW-1:0] wadr,
  input  logic [7:0]        wdata,
  input  logic [MEM_AW-1:0] radr,
  output logic [7:0]        rdata
);

  logic [7:0] mem [MEM_DEPTH];

  // Capture received data bytes
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wadr] <= wdata;
    end
  end

  assign rdata = mem[radr];

endmodule

// File: rtl/fp_loader.sv
// Framed byte-stream loader driving the SAP-1 front-panel programming port.
// Buffers a 16-byte image, verifies its checksum, then writes memory and clears the CPU.
module fp_loader
  import sap1_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned CLEAR_CYCLES   = 4
) (
  input  logic       sysclk,
  input  logic       reset_n,
  input  logic       clken_oop,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  output logic       fp_prog,
  output logic       fp_write,
  output logic [3:0] fp_adr,
  output logic [7:0] fp_data,
  output logic       fp_clear,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned CW = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
  localparam logic [TW-1:0]     TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0]     CLEAR_LAST = CW'(CLEAR_CYCLES - 1);
  localparam logic [MEM_AW-1:0] IDX_LAST   = MEM_AW'(MEM_DEPTH - 1);

  fp_state_e         state_q, state_d;
  logic [MEM_AW-1:0] idx_q, idx_d;
  logic [7:0]        sum_q, sum_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [CW-1:0]     clr_q, clr_d;
  logic              err_q, err_d;
  logic              done_q, done_d;

  logic       accept;
  logic       buf_we;
  logic [7:0] buf_rdata;
  logic [7:0] sum_next;

  assign accept   = rx_valid && rx_ready;
  assign sum_next = sum_q + rx_data;

  fp_loader_buf u_buf (
    .clk   (sysclk),
    .we    (buf_we),
    .wadr  (idx_q),
    .wdata (rx_data),
    .radr  (idx_q),
    .rdata (buf_rdata)
  );

  // State and counter registers
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      sum_q   <= '0;
      timer_q <= '0;
      clr_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      timer_q <= timer_d;
      clr_q   <= clr_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic and front-panel outputs
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    sum_d    = sum_q;
    timer_d  = timer_q;
    clr_d    = clr_q;
    err_d    = err_q;
    done_d   = 1'b0;
    buf_we   = 1'b0;
    rx_ready = 1'b0;
    fp_prog  = 1'b0;
    fp_write = 1'b0;
    fp_clear = 1'b0;

    unique case (state_q)
      StIdle: begin
        rx_ready = 1'b1;
        if (accept && (rx_data == SYNC_BYTE)) begin
          state_d = StRecv;
          idx_d   = '0;
          sum_d   = '0;
          timer_d = '0;
          err_d   = 1'b0;
        end
      end
      StRecv: begin
        rx_ready = 1'b1;
        if (accept) begin
          buf_we  = 1'b1;
          sum_d   = sum_next;
          idx_d   = idx_q + MEM_AW'(1);
          timer_d = '0;
          if (idx_q == IDX_LAST) begin
            state_d = StCsum;
          end
        end else if (timer_q == TIMER_LAST) begin
          state_d = StIdle;
          err_d   = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      StCsum: begin
        rx_ready = 1'b1;
        if (accept) begin
          if (sum_next == 8'h00) begin
            state_d = StWrite;
            idx_d   = '0;
          end else begin
            state_d = StIdle;
            err_d   = 1'b1;
          end
        end else if (timer_q == TIMER_LAST) begin
          state_d = StIdle;
          err_d   = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      StWrite: begin
        fp_prog  = 1'b1;
        fp_write = 1'b1;
        // Address only moves on a memory commit edge
        if (clken_oop) begin
          if (idx_q == IDX_LAST) begin
            state_d = StClear;
            clr_d   = '0;
          end else begin
            idx_d = idx_q + MEM_AW'(1);
          end
        end
      end
      StClear: begin
        fp_clear = 1'b1;
        if (clr_q == CLEAR_LAST) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else begin
          clr_d = clr_q + CW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign fp_adr  = fp_prog ? idx_q : '0;
  assign fp_data = fp_prog ? buf_rdata : '0;
  assign busy    = (state_q != StIdle);
  assign done    = done_q;
  assign err     = err_q;

endmodule
